// File: rtl/pipelined_aligner_if.sv
// Valid/ready bundle between the unpack stage, the fraction aligner and the significand adder.
// master is the surrounding datapath's view; slave is the aligner's view.
interface pipelined_aligner_if #(
  parameter int FRAC_WIDTH = 24,
  parameter int EXP_WIDTH  = 8,
  parameter int EXTRA_BITS = 24
);
  localparam int AW = FRAC_WIDTH + EXTRA_BITS + 1;

  logic                  in_valid;
  logic                  in_ready;
  logic                  sort_enable;
  logic                  sign_a;
  logic                  sign_b;
  logic [EXP_WIDTH-1:0]  exp_a;
  logic [EXP_WIDTH-1:0]  exp_b;
  logic [FRAC_WIDTH-1:0] frac_a;
  logic [FRAC_WIDTH-1:0] frac_b;

  logic                  out_valid;
  logic                  out_ready;
  logic                  sorted_sign_a;
  logic                  sorted_sign_b;
  logic [EXP_WIDTH-1:0]  sorted_exp_a;
  logic [EXP_WIDTH-1:0]  sorted_exp_b;
  logic [FRAC_WIDTH-1:0] sorted_frac_a;
  logic [FRAC_WIDTH-1:0] sorted_frac_b;
  logic                  exchanged;
  logic [AW-1:0]         aligned_frac_b;
  logic                  sticky;

  modport master (
    output in_valid, sort_enable, sign_a, sign_b, exp_a, exp_b, frac_a, frac_b, out_ready,
    input  in_ready, out_valid, sorted_sign_a, sorted_sign_b, sorted_exp_a, sorted_exp_b,
           sorted_frac_a, sorted_frac_b, exchanged, aligned_frac_b, sticky
  );

  modport slave (
    input  in_valid, sort_enable, sign_a, sign_b, exp_a, exp_b, frac_a, frac_b, out_ready,
    output in_ready, out_valid, sorted_sign_a, sorted_sign_b, sorted_exp_a, sorted_exp_b,
           sorted_frac_a, sorted_frac_b, exchanged, aligned_frac_b, sticky
  );
endinterface

// File: rtl/pipelined_aligner.sv
// Two-stage fraction aligner: stage 1 sorts operands by magnitude and derives the shift,
// stage 2 right-shifts the smaller fraction into a widened field and collects a sticky bit.
module pipelined_aligner #(
  parameter int FRAC_WIDTH = 24,
  parameter int EXP_WIDTH  = 8,
  parameter int EXTRA_BITS = 24
) (
  input logic             clk,
  input logic             reset_n,
  pipelined_aligner_if.slave bus
);
  localparam int AW = FRAC_WIDTH + EXTRA_BITS + 1;
  localparam int SW = $clog2(AW + 1);
  localparam int DW = EXP_WIDTH + 1;

  typedef struct packed {
    logic                  sign_a;
    logic                  sign_b;
    logic [EXP_WIDTH-1:0]  exp_a;
    logic [EXP_WIDTH-1:0]  exp_b;
    logic [FRAC_WIDTH-1:0] frac_a;
    logic [FRAC_WIDTH-1:0] frac_b;
    logic                  exchanged;
  } beat_t;

  logic          s1_valid_reg;
  beat_t         s1_beat_reg;
  logic [SW-1:0] s1_shift_reg;
  logic          s2_valid_reg;
  beat_t         s2_beat_reg;
  logic [AW-1:0] s2_aligned_reg;
  logic          s2_sticky_reg;

  logic          ready1;
  logic          ready2;
  logic          swap;
  beat_t         s1_beat_next;
  logic [DW-1:0] diff;
  logic [SW-1:0] s1_shift_next;

  logic [2*AW-1:0] wide_v;
  logic [2*AW-1:0] wide_shifted;
  logic [AW-1:0]   s2_aligned_next;
  logic            s2_sticky_next;

  // A stage may take a new beat when it is empty or its content moves on this cycle.
  assign ready2       = !s2_valid_reg || bus.out_ready;
  assign ready1       = !s1_valid_reg || ready2;
  assign bus.in_ready = ready1;

  // Equal magnitudes never swap, so a tie keeps operand a on top.
  assign swap = bus.sort_enable &&
                (($signed(bus.exp_b) > $signed(bus.exp_a)) ||
                 ((bus.exp_a == bus.exp_b) && (bus.frac_b > bus.frac_a)));

  always_comb begin
    s1_beat_next           = '0;
    s1_beat_next.exchanged = swap;
    if (swap) begin
      s1_beat_next.sign_a = bus.sign_b;
      s1_beat_next.sign_b = bus.sign_a;
      s1_beat_next.exp_a  = bus.exp_b;
      s1_beat_next.exp_b  = bus.exp_a;
      s1_beat_next.frac_a = bus.frac_b;
      s1_beat_next.frac_b = bus.frac_a;
    end else begin
      s1_beat_next.sign_a = bus.sign_a;
      s1_beat_next.sign_b = bus.sign_b;
      s1_beat_next.exp_a  = bus.exp_a;
      s1_beat_next.exp_b  = bus.exp_b;
      s1_beat_next.frac_a = bus.frac_a;
      s1_beat_next.frac_b = bus.frac_b;
    end
  end

  // Sign-extend by one bit so the difference of any two exponents fits without wrapping.
  assign diff = {s1_beat_next.exp_a[EXP_WIDTH-1], s1_beat_next.exp_a}
              - {s1_beat_next.exp_b[EXP_WIDTH-1], s1_beat_next.exp_b};

  always_comb begin
    s1_shift_next = '0;
    if (bus.sort_enable) begin
      if (32'(diff) >= AW) begin
        s1_shift_next = SW'(AW);
      end else begin
        s1_shift_next = SW'(diff);
      end
    end
  end

  // Upper half becomes the aligned field; lower half catches everything shifted past its LSB.
  assign wide_v          = {1'b0, s1_beat_reg.frac_b, {EXTRA_BITS{1'b0}}, {AW{1'b0}}};
  assign wide_shifted    = wide_v >> s1_shift_reg;
  assign s2_aligned_next = wide_shifted[2*AW-1:AW];
  assign s2_sticky_next  = |wide_shifted[AW-1:0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_reg   <= 1'b0;
      s1_beat_reg    <= '0;
      s1_shift_reg   <= '0;
      s2_valid_reg   <= 1'b0;
      s2_beat_reg    <= '0;
      s2_aligned_reg <= '0;
      s2_sticky_reg  <= 1'b0;
    end else begin
      if (ready1) begin
        s1_valid_reg <= bus.in_valid;
      end
      if (ready1 && bus.in_valid) begin
        s1_beat_reg  <= s1_beat_next;
        s1_shift_reg <= s1_shift_next;
      end
      if (ready2) begin
        s2_valid_reg <= s1_valid_reg;
      end
      if (ready2 && s1_valid_reg) begin
        s2_beat_reg    <= s1_beat_reg;
        s2_aligned_reg <= s2_aligned_next;
        s2_sticky_reg  <= s2_sticky_next;
      end
    end
  end

  assign bus.out_valid      = s2_valid_reg;
  assign bus.sorted_sign_a  = s2_beat_reg.sign_a;
  assign bus.sorted_sign_b  = s2_beat_reg.sign_b;
  assign bus.sorted_exp_a   = s2_beat_reg.exp_a;
  assign bus.sorted_exp_b   = s2_beat_reg.exp_b;
  assign bus.sorted_frac_a  = s2_beat_reg.frac_a;
  assign bus.sorted_frac_b  = s2_beat_reg.frac_b;
  assign bus.exchanged      = s2_beat_reg.exchanged;
  assign bus.aligned_frac_b = s2_aligned_reg;
  assign bus.sticky         = s2_sticky_reg;
endmodule

// File: tb/tb_pipelined_aligner.sv
// Directed bench for pipelined_aligner with default parameters: one task per scenario,
// hand-computed expectations, inputs driven and outputs sampled 1ns after the rising edge.
module tb_pipelined_aligner;
  localparam int FW = 24;
  localparam int EW = 8;
  localparam int XB = 24;
  localparam int AW = FW + XB + 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_compared = 0;
  int   n_mismatched = 0;

  always #5 clk = ~clk;

  pipelined_aligner_if #(.FRAC_WIDTH(FW), .EXP_WIDTH(EW), .EXTRA_BITS(XB)) bus ();

  pipelined_aligner #(.FRAC_WIDTH(FW), .EXP_WIDTH(EW), .EXTRA_BITS(XB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  task automatic drive(input logic se, input logic sa, input logic [EW-1:0] ea, input logic [FW-1:0] fa,
                       input logic sb, input logic [EW-1:0] eb, input logic [FW-1:0] fb);
    bus.in_valid    = 1'b1;
    bus.sort_enable = se;
    bus.sign_a      = sa;
    bus.exp_a       = ea;
    bus.frac_a      = fa;
    bus.sign_b      = sb;
    bus.exp_b       = eb;
    bus.frac_b      = fb;
  endtask

  // Pushes one beat into an empty pipe with out_ready high and waits for it to reach the outputs.
  task automatic run_single(input logic se, input logic sa, input logic [EW-1:0] ea, input logic [FW-1:0] fa,
                            input logic sb, input logic [EW-1:0] eb, input logic [FW-1:0] fb);
    drive(se, sa, ea, fa, sb, eb, fb);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.sort_enable = 1'b0;
    bus.sign_a = 1'b0; bus.sign_b = 1'b0; bus.exp_a = '0; bus.exp_b = '0; bus.frac_a = '0; bus.frac_b = '0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_compared++; if (bus.out_valid !== 1'b0) begin n_mismatched++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_compared++; if (bus.in_ready !== 1'b1) begin n_mismatched++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_compared++; if (bus.aligned_frac_b !== 49'h0) begin n_mismatched++; $display("FAIL reset_aligned: got %h want 0", bus.aligned_frac_b); end
    n_compared++; if ({bus.sticky, bus.exchanged} !== 2'b00) begin n_mismatched++; $display("FAIL reset_sticky_exch: got %b want 00", {bus.sticky, bus.exchanged}); end
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    drive(1'b1, 1'b0, 8'd3, 24'hC00000, 1'b0, 8'd1, 24'h800000);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_compared++; if (bus.out_valid !== 1'b0) begin n_mismatched++; $display("FAIL basic_early_valid: got %b want 0", bus.out_valid); end
    @(posedge clk); #1;
    n_compared++; if (bus.out_valid !== 1'b1) begin n_mismatched++; $display("FAIL basic_valid: got %b want 1", bus.out_valid); end
    n_compared++; if (bus.exchanged !== 1'b0) begin n_mismatched++; $display("FAIL basic_exchanged: got %b want 0", bus.exchanged); end
    n_compared++; if (bus.aligned_frac_b !== 49'h0200000000000) begin n_mismatched++; $display("FAIL basic_aligned: got %h want 0200000000000", bus.aligned_frac_b); end
    n_compared++; if (bus.sticky !== 1'b0) begin n_mismatched++; $display("FAIL basic_sticky: got %b want 0", bus.sticky); end
    n_compared++; if (bus.sorted_exp_b !== 8'd1) begin n_mismatched++; $display("FAIL basic_exp_b: got %0d want 1", bus.sorted_exp_b); end
    @(posedge clk); #1;
    n_compared++; if (bus.out_valid !== 1'b0) begin n_mismatched++; $display("FAIL basic_drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_exchange;
    run_single(1'b1, 1'b0, 8'd0, 24'h800000, 1'b1, 8'd5, 24'hA00000);
    n_compared++; if (bus.exchanged !== 1'b1) begin n_mismatched++; $display("FAIL exch_flag: got %b want 1", bus.exchanged); end
    n_compared++; if (bus.sorted_exp_a !== 8'd5) begin n_mismatched++; $display("FAIL exch_exp_a: got %0d want 5", bus.sorted_exp_a); end
    n_compared++; if (bus.sorted_frac_a !== 24'hA00000) begin n_mismatched++; $display("FAIL exch_frac_a: got %h want a00000", bus.sorted_frac_a); end
    n_compared++; if ({bus.sorted_sign_a, bus.sorted_sign_b} !== 2'b10) begin n_mismatched++; $display("FAIL exch_signs: got %b want 10", {bus.sorted_sign_a, bus.sorted_sign_b}); end
    n_compared++; if (bus.aligned_frac_b !== 49'h0040000000000) begin n_mismatched++; $display("FAIL exch_aligned: got %h want 0040000000000", bus.aligned_frac_b); end
    n_compared++; if (bus.sticky !== 1'b0) begin n_mismatched++; $display("FAIL exch_sticky: got %b want 0", bus.sticky); end
    run_single(1'b1, 1'b0, 8'd2, 24'hA00000, 1'b0, 8'd2, 24'hA00000);
    n_compared++; if (bus.exchanged !== 1'b0) begin n_mismatched++; $display("FAIL exch_tie: got %b want 0", bus.exchanged); end
    n_compared++; if (bus.aligned_frac_b !== 49'h0A00000000000) begin n_mismatched++; $display("FAIL exch_tie_aligned: got %h want 0a00000000000", bus.aligned_frac_b); end
    run_single(1'b1, 1'b0, 8'd2, 24'h900000, 1'b0, 8'd2, 24'hA00000);
    n_compared++; if (bus.exchanged !== 1'b1) begin n_mismatched++; $display("FAIL exch_frac_cmp: got %b want 1", bus.exchanged); end
    n_compared++; if (bus.sorted_frac_b !== 24'h900000) begin n_mismatched++; $display("FAIL exch_frac_b: got %h want 900000", bus.sorted_frac_b); end
  endtask

  task automatic test_sticky;
    run_single(1'b1, 1'b0, 8'd47, 24'h800000, 1'b0, 8'd0, 24'h800001);
    n_compared++; if ({bus.aligned_frac_b, bus.sticky} !== {49'h1, 1'b1}) begin n_mismatched++; $display("FAIL sticky_d47: got %h/%b want 1/1", bus.aligned_frac_b, bus.sticky); end
    run_single(1'b1, 1'b0, 8'd48, 24'h800000, 1'b0, 8'd0, 24'h800001);
    n_compared++; if ({bus.aligned_frac_b, bus.sticky} !== {49'h0, 1'b1}) begin n_mismatched++; $display("FAIL sticky_d48: got %h/%b want 0/1", bus.aligned_frac_b, bus.sticky); end
    run_single(1'b1, 1'b0, 8'd50, 24'h800000, 1'b0, 8'hCE, 24'h800001);
    n_compared++; if ({bus.aligned_frac_b, bus.sticky} !== {49'h0, 1'b1}) begin n_mismatched++; $display("FAIL sticky_d100: got %h/%b want 0/1", bus.aligned_frac_b, bus.sticky); end
    n_compared++; if (bus.exchanged !== 1'b0) begin n_mismatched++; $display("FAIL sticky_d100_exch: got %b want 0", bus.exchanged); end
    run_single(1'b1, 1'b0, 8'd50, 24'h800000, 1'b0, 8'hCE, 24'h000000);
    n_compared++; if ({bus.aligned_frac_b, bus.sticky} !== {49'h0, 1'b0}) begin n_mismatched++; $display("FAIL sticky_zero: got %h/%b want 0/0", bus.aligned_frac_b, bus.sticky); end
  endtask

  task automatic test_passthrough;
    run_single(1'b0, 1'b0, 8'd1, 24'h800000, 1'b1, 8'd6, 24'h900000);
    n_compared++; if (bus.exchanged !== 1'b0) begin n_mismatched++; $display("FAIL pass_exch: got %b want 0", bus.exchanged); end
    n_compared++; if (bus.aligned_frac_b !== 49'h0900000000000) begin n_mismatched++; $display("FAIL pass_aligned: got %h want 0900000000000", bus.aligned_frac_b); end
    n_compared++; if (bus.sticky !== 1'b0) begin n_mismatched++; $display("FAIL pass_sticky: got %b want 0", bus.sticky); end
    n_compared++; if (bus.sorted_exp_a !== 8'd1) begin n_mismatched++; $display("FAIL pass_exp_a: got %0d want 1", bus.sorted_exp_a); end
  endtask

  task automatic test_back_to_back;
    logic [FW-1:0] fb [4];
    fb[0] = 24'h100000; fb[1] = 24'h200000; fb[2] = 24'h300000; fb[3] = 24'h400000;
    drive(1'b1, 1'b0, 8'd0, 24'hF00000, 1'b0, 8'd0, fb[0]);
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (c <= 3) drive(1'b1, 1'b0, 8'd0, 24'hF00000, 1'b0, 8'd0, fb[c]);
      else bus.in_valid = 1'b0;
      if (c >= 2 && c <= 5) begin
        n_compared++; if ({bus.out_valid, bus.sorted_frac_b} !== {1'b1, fb[c-2]}) begin n_mismatched++; $display("FAIL b2b_beat%0d: got %b/%h want 1/%h", c - 2, bus.out_valid, bus.sorted_frac_b, fb[c-2]); end
      end else begin
        n_compared++; if (bus.out_valid !== 1'b0) begin n_mismatched++; $display("FAIL b2b_idle_c%0d: got %b want 0", c, bus.out_valid); end
      end
    end
  endtask

  task automatic test_backpressure;
    bus.out_ready = 1'b0;
    drive(1'b0, 1'b0, 8'd0, 24'h0A0A0A, 1'b0, 8'd0, 24'h111111);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 8'd0, 24'h0B0B0B, 1'b0, 8'd0, 24'h222222);
    n_compared++; if (bus.in_ready !== 1'b1) begin n_mismatched++; $display("FAIL bp_ready_one: got %b want 1", bus.in_ready); end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 8'd0, 24'h0C0C0C, 1'b0, 8'd0, 24'h333333);
    n_compared++; if (bus.in_ready !== 1'b0) begin n_mismatched++; $display("FAIL bp_full: got %b want 0", bus.in_ready); end
    n_compared++; if ({bus.out_valid, bus.sorted_frac_b} !== {1'b1, 24'h111111}) begin n_mismatched++; $display("FAIL bp_head: got %b/%h want 1/111111", bus.out_valid, bus.sorted_frac_b); end
    repeat (2) @(posedge clk);
    #1;
    n_compared++; if ({bus.out_valid, bus.sorted_frac_b, bus.sorted_frac_a} !== {1'b1, 24'h111111, 24'h0A0A0A}) begin n_mismatched++; $display("FAIL bp_hold: got %b/%h/%h want 1/111111/0a0a0a", bus.out_valid, bus.sorted_frac_b, bus.sorted_frac_a); end
    n_compared++; if (bus.in_ready !== 1'b0) begin n_mismatched++; $display("FAIL bp_still_full: got %b want 0", bus.in_ready); end
    bus.out_ready = 1'b1;
    #1;
    n_compared++; if (bus.in_ready !== 1'b1) begin n_mismatched++; $display("FAIL bp_ready_comb: got %b want 1", bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_compared++; if ({bus.out_valid, bus.sorted_frac_b} !== {1'b1, 24'h222222}) begin n_mismatched++; $display("FAIL bp_beat2: got %b/%h want 1/222222", bus.out_valid, bus.sorted_frac_b); end
    @(posedge clk); #1;
    n_compared++; if ({bus.out_valid, bus.sorted_frac_b} !== {1'b1, 24'h333333}) begin n_mismatched++; $display("FAIL bp_beat3: got %b/%h want 1/333333", bus.out_valid, bus.sorted_frac_b); end
    @(posedge clk); #1;
    n_compared++; if (bus.out_valid !== 1'b0) begin n_mismatched++; $display("FAIL bp_drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_reset_midstream;
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b0, 8'd0, 24'h800000, 1'b1, 8'd5, 24'hA00000);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 8'd48, 24'h800000, 1'b0, 8'd0, 24'h800001);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_compared++; if ({bus.out_valid, bus.exchanged} !== 2'b11) begin n_mismatched++; $display("FAIL rst_pre_full: got %b want 11", {bus.out_valid, bus.exchanged}); end
    reset_n = 1'b0;
    @(posedge clk); #1;
    n_compared++; if (bus.out_valid !== 1'b0) begin n_mismatched++; $display("FAIL rst_mid_valid: got %b want 0", bus.out_valid); end
    n_compared++; if ({bus.sorted_frac_a, bus.sorted_exp_a, bus.aligned_frac_b, bus.exchanged, bus.sorted_sign_a} !== '0) begin n_mismatched++; $display("FAIL rst_mid_data: got %h/%h/%h/%b/%b want all 0", bus.sorted_frac_a, bus.sorted_exp_a, bus.aligned_frac_b, bus.exchanged, bus.sorted_sign_a); end
    n_compared++; if (bus.in_ready !== 1'b1) begin n_mismatched++; $display("FAIL rst_mid_ready: got %b want 1", bus.in_ready); end
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    n_compared++; if (bus.out_valid !== 1'b0) begin n_mismatched++; $display("FAIL rst_stale: got %b want 0", bus.out_valid); end
    run_single(1'b1, 1'b0, 8'd3, 24'hC00000, 1'b0, 8'd1, 24'h800000);
    n_compared++; if ({bus.out_valid, bus.aligned_frac_b} !== {1'b1, 49'h0200000000000}) begin n_mismatched++; $display("FAIL rst_next_beat: got %b/%h want 1/0200000000000", bus.out_valid, bus.aligned_frac_b); end
    @(posedge clk); #1;
    n_compared++; if (bus.out_valid !== 1'b0) begin n_mismatched++; $display("FAIL rst_no_dup: got %b want 0", bus.out_valid); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_exchange;
    test_sticky;
    test_passthrough;
    test_back_to_back;
    test_backpressure;
    test_reset_midstream;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
